// File: rtl/neo_pkg.sv
// ============================================================================
// neo_pkg : shared types and defaults for the NEO frame memory
// Revision: 1.0
// ============================================================================
`default_nettype none

package neo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } neo_fm_state_t;

    localparam int NEO_RUN_EXTRA_DEF = 3;

endpackage

`default_nettype wire

// File: rtl/neo_regfile.sv
// ============================================================================
// neo_regfile : register array, one sync write, one registered read, one async read
// Revision: 1.0
// ============================================================================
`default_nettype none

module neo_regfile #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [$clog2(M)-1:0] waddr,
    input  logic [N-1:0]         wdata,
    input  logic [$clog2(M)-1:0] raddr_q,
    output logic [N-1:0]         rdata_q,
    input  logic [$clog2(M)-1:0] raddr_a,
    output logic [N-1:0]         rdata_a
);

    // Storage is deliberately left out of reset; only the read register clears.
    logic [N-1:0] mem [M];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_q];
        end
    end

    assign rdata_a = mem[raddr_a];

endmodule

`default_nettype wire

// File: rtl/neo_frame_mem.sv
// ============================================================================
// neo_frame_mem : loads a sample frame, runs NEO over it, streams results out
// Revision: 1.0
// ============================================================================
`default_nettype none

module neo_frame_mem
    import neo_pkg::*;
#(
    parameter int N         = 8,
    parameter int M         = 16,
    parameter int RUN_EXTRA = NEO_RUN_EXTRA_DEF
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N-1:0]         s_data,
    output logic                 neo_reset,
    input  logic [$clog2(M)-1:0] neo_raddr,
    output logic [N-1:0]         neo_rdata,
    input  logic [$clog2(M)-1:0] neo_waddr,
    input  logic [N-1:0]         neo_wdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int            AW        = $clog2(M);
    localparam int            RW        = $clog2(M + RUN_EXTRA) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(M + RUN_EXTRA - 1);

    neo_fm_state_t state, state_nxt;
    logic [AW-1:0] load_cnt;
    logic [AW-1:0] drain_cnt;
    logic [RW-1:0] run_cnt;
    logic [N-1:0]  res_rdata;
    logic          s_hs;
    logic          m_hs;
    logic [N-1:0]  unused_smp_rdata_a;
    logic [N-1:0]  unused_res_rdata_q;

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid && m_ready;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            load_cnt   <= '0;
            drain_cnt  <= '0;
            run_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= m_hs && m_last;
            if (s_hs) begin
                load_cnt <= (load_cnt == LAST_ADDR) ? '0 : load_cnt + 1'b1;
            end
            if (state == RUN) begin
                run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + 1'b1;
            end
            if (m_hs) begin
                drain_cnt <= m_last ? '0 : drain_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        neo_reset = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (load_cnt == LAST_ADDR)) state_nxt = RUN;
            end
            RUN: begin
                neo_reset = 1'b1;
                if (run_cnt == RUN_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_last  = (drain_cnt == LAST_ADDR);
                if (m_ready && m_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result bus is forced to zero outside DRAIN so stale RAM data never leaks.
    assign m_data = m_valid ? res_rdata : '0;

    neo_regfile #(.N(N), .M(M)) u_smp_ram (
        .clk     (Clk),
        .rst     (reset),
        .we      (s_hs),
        .waddr   (load_cnt),
        .wdata   (s_data),
        .raddr_q (neo_raddr),
        .rdata_q (neo_rdata),
        .raddr_a ('0),
        .rdata_a (unused_smp_rdata_a)
    );

    neo_regfile #(.N(N), .M(M)) u_res_ram (
        .clk     (Clk),
        .rst     (reset),
        .we      (state == RUN),
        .waddr   (neo_waddr),
        .wdata   (neo_wdata),
        .raddr_q ('0),
        .rdata_q (unused_res_rdata_q),
        .raddr_a (drain_cnt),
        .rdata_a (res_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_neo_frame_mem.sv
// ============================================================================
// tb_neo_frame_mem : scoreboard bench for neo_frame_mem with a NEO stub
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_neo_frame_mem;

    localparam int N      = 8;
    localparam int M      = 16;
    localparam int RX     = 3;
    localparam int AW     = 4;
    localparam int RUNLEN = M + RX;

    logic          Clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          enable    = 1'b0;
    logic          s_valid   = 1'b0;
    logic          m_ready   = 1'b0;
    logic [N-1:0]  s_data    = '0;
    logic [N-1:0]  neo_wdata = '0;
    logic [AW-1:0] neo_raddr = '0;
    logic [AW-1:0] neo_waddr = '0;
    logic          s_ready, neo_reset, m_valid, m_last, busy, frame_done;
    logic [N-1:0]  neo_rdata, m_data;

    neo_frame_mem #(.N(N), .M(M), .RUN_EXTRA(RX)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .neo_reset  (neo_reset),
        .neo_raddr  (neo_raddr),
        .neo_rdata  (neo_rdata),
        .neo_waddr  (neo_waddr),
        .neo_wdata  (neo_wdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    int           errors   = 0;
    int           checks   = 0;
    int           fd_count = 0;
    bit           last_hs_seen = 1'b0;
    logic [N:0]   exp_q[$];          // {last, data}
    logic [N-1:0] smp_model [M];
    logic [N-1:0] res_model [M];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: result beats against the scoreboard, frame_done against handshakes.
    always @(negedge Clk) begin
        check("frame_done", frame_done, last_hs_seen);
        if (frame_done) fd_count++;
        last_hs_seen = 1'b0;
        if (!m_valid) begin
            check("m_data_idle", m_data, 0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL m_unexpected: actual=%0h expected=no beat at %0t", m_data, $time);
        end else begin
            check("m_data", m_data, exp_q[0][N-1:0]);
            check("m_last", m_last, exp_q[0][N]);
            if (m_ready) begin
                last_hs_seen = exp_q[0][N];
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_frame(input bit gappy, input bit seq, input int base,
                             input int rst_at, input bit stall, input bit rnd_ready);
        logic [AW-1:0] wa [RUNLEN];
        logic [N-1:0]  wd [RUNLEN];
        logic [AW-1:0] ra;
        int            k, guard, beat, stall_left, fd0;
        bit            hs;

        check("busy_idle", busy, 0);
        enable = 1'b1;
        tick();
        enable = 1'b0;

        k = 0;
        guard = 0;
        while (k < M && guard < 400) begin
            s_valid   = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data    = seq ? N'(base + k) : N'($urandom);
            neo_waddr = AW'($urandom);
            neo_wdata = N'($urandom);
            check("s_ready_load", s_ready, 1);
            check("neo_reset_load", neo_reset, 0);
            hs = s_valid && s_ready;
            if (hs) smp_model[k] = s_data;
            tick();
            if (hs) k++;
            guard++;
        end
        s_valid = 1'b0;
        if (k < M) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: actual=%0d expected=%0d samples", k, M);
            return;
        end
        check("s_ready_run", s_ready, 0);

        for (int j = 0; j < RUNLEN; j++) begin
            wa[j] = seq ? AW'(j % M) : AW'($urandom);
            wd[j] = seq ? (N'(j % M) ^ 8'hA5) : N'($urandom);
        end
        for (int j = 0; j < RUNLEN; j++) begin
            neo_waddr = wa[j];
            neo_wdata = wd[j];
            ra        = (seq && j == 0) ? AW'(5) : AW'($urandom);
            neo_raddr = ra;
            check("neo_reset_run", neo_reset, 1);
            check("busy_run", busy, 1);
            if (j == rst_at) reset = 1'b1;
            tick();
            res_model[wa[j]] = wd[j];
            if (j == rst_at) begin
                reset = 1'b0;
                check("neo_reset_after_rst", neo_reset, 0);
                check("busy_after_rst", busy, 0);
                check("neo_rdata_rst", neo_rdata, 0);
                return;
            end
            check("neo_rdata", neo_rdata, smp_model[ra]);
            if (seq && j == 0) check("neo_rdata_addr5", neo_rdata, N'(base + 5));
        end
        check("neo_reset_drain", neo_reset, 0);

        for (int a = 0; a < M; a++) exp_q.push_back({(a == M - 1), res_model[a]});
        beat       = 0;
        stall_left = 4;
        guard      = 0;
        fd0        = fd_count;
        while (busy && guard < 400) begin
            check("m_valid_drain", m_valid, 1);
            if (stall && beat == 7 && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            neo_waddr = AW'($urandom);
            neo_wdata = N'($urandom);
            hs = m_valid && m_ready;
            tick();
            if (hs) beat++;
            guard++;
        end
        m_ready = 1'b0;
        tick();
        check("beat_count", beat, M);
        check("queue_empty", exp_q.size(), 0);
        check("frame_done_count", fd_count - fd0, 1);
        check("busy_end", busy, 0);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_neo_reset", neo_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_neo_rdata", neo_rdata, 0);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_without_enable", busy, 0);

        run_frame(1'b0, 1'b1, 0,  -1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 16, -1, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 0,  -1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 0,  -1, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 0,  -1, 1'b1, 1'b1);
        run_frame(1'b0, 1'b1, 0,   5, 1'b0, 1'b0);
        check("queue_empty_after_rst", exp_q.size(), 0);
        run_frame(1'b0, 1'b1, 32, -1, 1'b0, 1'b0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
